seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver. It replaces the fixed 8-digit scan logic in the top level and adds the following:
- Configurable digit count and refresh period.
- Frame-synchronous double-buffered glyph load, so the display never tears.
- Per-digit blink and decimal point.
- 16-level brightness PWM and an anti-ghosting guard interval.

It sits between the game/timer logic, which produces glyph codes, and the board anode/cathode pins.

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 216 +++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Glyph-load bus between the game/timer logic and the seven-segment scan driver.
// Latency: none (wires only); load_pending is produced by the driver.
// Backpressure: none; a load raised while one is pending replaces the staged content.
// Signals: load (request), glyphs (NUM_DIGITS*GLYPH_W, slot i -> anode bit i),
//          dp_mask, blink_mask (one bit per digit), load_pending (driver -> source).
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 8,
   parameter int GLYPH_W    = 5
);
   logic                          load;
   logic [NUM_DIGITS*GLYPH_W-1:0] glyphs;
   logic [NUM_DIGITS-1:0]         dp_mask;
   logic [NUM_DIGITS-1:0]         blink_mask;
   logic                          load_pending;

   modport master (
      output load, glyphs, dp_mask, blink_mask,
      input  load_pending
   );

   modport slave (
      input  load, glyphs, dp_mask, blink_mask,
      output load_pending
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: frame-synchronous double-buffered glyphs, blink, dp, PWM, guard.
// Latency: pins are registered, one cycle behind the scan counters; new content appears next frame.
// Backpressure: none; load is always accepted, staged until the frame wrap, last request wins.
// Ports: clock_100Mhz, reset (async, active low), enable, brightness[3:0], load_bus (slave side of
//        seg_scan_driver_if), Anode_Activate (active-low digits), LED_out {a..g} active low,
//        dp_out active low, frame_done (one-cycle pulse on the last digit's final dwell cycle).
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int GLYPH_W      = 5,
   parameter int REFRESH_LOG2 = 17,
   parameter int GUARD        = 64,
   parameter int BLINK_DIV    = 25000000
) (
   input  logic                  clock_100Mhz,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [3:0]            brightness,
   seg_scan_driver_if.slave      load_bus,
   output logic [NUM_DIGITS-1:0] Anode_Activate,
   output logic [6:0]            LED_out,
   output logic                  dp_out,
   output logic                  frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [IDX_W-1:0]        IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
   localparam logic [REFRESH_LOG2-1:0] GUARD_CNT   = REFRESH_LOG2'(GUARD);
   localparam logic [REFRESH_LOG2-1:0] DWELL_LAST  = '1;
   localparam logic [BLK_W-1:0]        BLINK_LAST  = BLK_W'(BLINK_DIV - 1);
   localparam logic [GLYPH_W-1:0]      GLYPH_BLANK = GLYPH_W'(20);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } ld_state_t;

   // Code -> active-low segments {a,b,c,d,e,f,g}; anything undefined is blank.
   function automatic logic [6:0] decode(input logic [GLYPH_W-1:0] code);
      logic [31:0] c;
      c = 32'(code);
      case (c)
         32'd0:   decode = 7'b0000001;
         32'd1:   decode = 7'b1001111;
         32'd2:   decode = 7'b0010010;
         32'd3:   decode = 7'b0000110;
         32'd4:   decode = 7'b1001100;
         32'd5:   decode = 7'b0100100;
         32'd6:   decode = 7'b0100000;
         32'd7:   decode = 7'b0001111;
         32'd8:   decode = 7'b0000000;
         32'd9:   decode = 7'b0000100;
         32'd10:  decode = 7'b0011001;
         32'd11:  decode = 7'b0110000;
         32'd12:  decode = 7'b0001000;
         32'd13:  decode = 7'b1000010;
         32'd14:  decode = 7'b1000100;
         32'd15:  decode = 7'b1000001;
         32'd16:  decode = 7'b1110001;
         32'd17:  decode = 7'b1010101;
         32'd18:  decode = 7'b0001001;
         32'd19:  decode = 7'b1110000;
         32'd21:  decode = 7'b0011010;
         32'd22:  decode = 7'b0110001;
         default: decode = 7'b1111111;
      endcase
   endfunction

   // ---------------------------------------------------------------- scan counters
   logic [REFRESH_LOG2-1:0] dwell_cnt;
   logic [IDX_W-1:0]        digit_idx;
   logic                    dwell_wrap;
   logic                    frame_wrap;

   assign dwell_wrap = (dwell_cnt == DWELL_LAST);
   assign frame_wrap = dwell_wrap && (digit_idx == '0);
   assign frame_done = frame_wrap;

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         dwell_cnt <= '0;
         digit_idx <= IDX_LAST;
      end else begin
         dwell_cnt <= dwell_cnt + 1'b1;
         if (dwell_wrap) begin
            digit_idx <= (digit_idx == '0) ? IDX_LAST : digit_idx - 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- blink timebase
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_phase;

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- load FSM
   ld_state_t ld_state;
   ld_state_t ld_state_nxt;
   logic      stage_we;
   logic      shadow_from_in;
   logic      shadow_from_stage;
   logic      pending;

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) ld_state <= IDLE;
      else        ld_state <= ld_state_nxt;
   end

   always_comb begin
      ld_state_nxt = ld_state;
      case (ld_state)
         IDLE:    if (load_bus.load && !frame_wrap) ld_state_nxt = PENDING;
         PENDING: if (frame_wrap)                   ld_state_nxt = IDLE;
         default:                                   ld_state_nxt = IDLE;
      endcase
   end

   // A load coinciding with the wrap bypasses staging, and also supersedes
   // anything already staged, so the newest request is what the next frame shows.
   always_comb begin
      stage_we          = 1'b0;
      shadow_from_in    = 1'b0;
      shadow_from_stage = 1'b0;
      pending           = (ld_state == PENDING);
      if (frame_wrap && load_bus.load)        shadow_from_in    = 1'b1;
      else if (frame_wrap && ld_state == PENDING) shadow_from_stage = 1'b1;
      else if (load_bus.load)                 stage_we          = 1'b1;
   end

   assign load_bus.load_pending = pending;

   // ---------------------------------------------------------------- staging / shadow
   logic [GLYPH_W-1:0]    in_glyph  [NUM_DIGITS];
   logic [GLYPH_W-1:0]    stg_glyph [NUM_DIGITS];
   logic [GLYPH_W-1:0]    sh_glyph  [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] stg_dp;
   logic [NUM_DIGITS-1:0] stg_blink;
   logic [NUM_DIGITS-1:0] sh_dp;
   logic [NUM_DIGITS-1:0] sh_blink;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_unpack
      assign in_glyph[g] = load_bus.glyphs[g*GLYPH_W +: GLYPH_W];
   end

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            stg_glyph[i] <= GLYPH_BLANK;
            sh_glyph[i]  <= GLYPH_BLANK;
         end
         stg_dp    <= '0;
         stg_blink <= '0;
         sh_dp     <= '0;
         sh_blink  <= '0;
      end else begin
         if (stage_we) begin
            stg_glyph <= in_glyph;
            stg_dp    <= load_bus.dp_mask;
            stg_blink <= load_bus.blink_mask;
         end
         if (shadow_from_in) begin
            sh_glyph <= in_glyph;
            sh_dp    <= load_bus.dp_mask;
            sh_blink <= load_bus.blink_mask;
         end else if (shadow_from_stage) begin
            sh_glyph <= stg_glyph;
            sh_dp    <= stg_dp;
            sh_blink <= stg_blink;
         end
      end
   end

   // ---------------------------------------------------------------- pin drive
   // Lit only past the guard window, while the top nibble of the dwell is within
   // the duty level, and outside the dark half of a blinking digit.
   logic                  digit_on;
   logic [NUM_DIGITS-1:0] anode_sel;

   always_comb begin
      digit_on = enable
               && (dwell_cnt >= GUARD_CNT)
               && (dwell_cnt[REFRESH_LOG2-1 -: 4] <= brightness)
               && !(blink_phase && sh_blink[digit_idx]);
      anode_sel = '0;
      anode_sel[digit_idx] = 1'b1;
   end

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         Anode_Activate <= '1;
         LED_out        <= 7'b1111111;
         dp_out         <= 1'b1;
      end else if (digit_on) begin
         Anode_Activate <= ~anode_sel;
         LED_out        <= decode(sh_glyph[digit_idx]);
         dp_out         <= ~sh_dp[digit_idx];
      end else begin
         Anode_Activate <= '1;
         LED_out        <= 7'b1111111;
         dp_out         <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 32-cycle dwell, guard 2, blink every 100 cycles.
// Latency: s_now is the scan state the DUT registers hold; pins show state s_now-1.
// Backpressure: n/a; loads are single-cycle pulses at chosen scan states.
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int GW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [3:0]    brightness = 4'd15;
   logic [ND-1:0] anode;
   logic [6:0]    led;
   logic          dp;
   logic          frame_done;

   seg_scan_driver_if #(.NUM_DIGITS(ND), .GLYPH_W(GW)) load_bus ();

   seg_scan_driver #(
      .NUM_DIGITS(ND), .GLYPH_W(GW), .REFRESH_LOG2(5), .GUARD(2), .BLINK_DIV(100)
   ) dut (
      .clock_100Mhz   (clk),
      .reset          (rst_n),
      .enable         (enable),
      .brightness     (brightness),
      .load_bus       (load_bus),
      .Anode_Activate (anode),
      .LED_out        (led),
      .dp_out         (dp),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int s_now = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      s_now++;
      @(negedge clk);
   endtask

   task automatic run_to(input int s);
      while (s_now < s) tick();
   endtask

   // Registered pins for scan state s are visible once the DUT has moved to s+1.
   task automatic expect_pins(input string tag, input int s, input logic [3:0] an,
                              input logic [6:0] seg, input logic d);
      run_to(s + 1);
      check_eq({tag, "/an"}, 32'(anode), 32'(an));
      check_eq({tag, "/seg"}, 32'(led), 32'(seg));
      check_eq({tag, "/dp"}, 32'(dp), 32'(d));
   endtask

   task automatic do_load(input int s, input logic [19:0] g, input logic [3:0] dpm,
                          input logic [3:0] blm);
      run_to(s);
      load_bus.load       = 1'b1;
      load_bus.glyphs     = g;
      load_bus.dp_mask    = dpm;
      load_bus.blink_mask = blm;
      tick();
      load_bus.load       = 1'b0;
   endtask

   initial begin
      load_bus.load       = 1'b0;
      load_bus.glyphs     = '0;
      load_bus.dp_mask    = '0;
      load_bus.blink_mask = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst/an", 32'(anode), 32'hF);
      check_eq("rst/seg", 32'(led), 32'h7F);
      check_eq("rst/dp", 32'(dp), 32'h1);
      check_eq("rst/fd", 32'(frame_done), 32'h0);
      check_eq("rst/lp", 32'(load_bus.load_pending), 32'h0);
      rst_n = 1'b1;
      s_now = 0;

      // Two frames with the display disabled: dark pins, frame_done every 128 cycles
      for (int s = 1; s <= 256; s++) begin
         run_to(s);
         check_eq("idle/an", 32'(anode), 32'hF);
         check_eq("idle/seg", 32'(led), 32'h7F);
         check_eq("idle/fd", 32'(frame_done), ((s % 128) == 127) ? 32'h1 : 32'h0);
      end

      // Load {3,2,1,0} mid-frame; old (blank) content holds until the wrap
      run_to(256);
      enable = 1'b1;
      do_load(260, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
      check_eq("ld1/lp", 32'(load_bus.load_pending), 32'h1);
      expect_pins("ld1/old", 300, 4'b1011, 7'b1111111, 1'b1);
      run_to(383);
      check_eq("ld1/lp_wrap", 32'(load_bus.load_pending), 32'h1);
      check_eq("ld1/fd", 32'(frame_done), 32'h1);
      run_to(384);
      check_eq("ld1/lp_clr", 32'(load_bus.load_pending), 32'h0);
      expect_pins("f3/guard0", 384, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("f3/guard1", 385, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("f3/d3a", 386, 4'b0111, 7'b0000110, 1'b1);
      expect_pins("f3/d3b", 415, 4'b0111, 7'b0000110, 1'b1);
      expect_pins("f3/d2", 418, 4'b1011, 7'b0010010, 1'b1);
      expect_pins("f3/d1", 450, 4'b1101, 7'b1001111, 1'b1);
      expect_pins("f3/d0g", 481, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("f3/d0", 482, 4'b1110, 7'b0000001, 1'b1);

      // Two loads while pending: the second wins
      do_load(520, {5'd4, 5'd5, 5'd6, 5'd7}, 4'b0000, 4'b0000);
      check_eq("ld2/lp", 32'(load_bus.load_pending), 32'h1);
      do_load(530, {5'd8, 5'd9, 5'd10, 5'd11}, 4'b0000, 4'b0000);
      expect_pins("ld2/old", 600, 4'b1101, 7'b1001111, 1'b1);
      expect_pins("f5/guard", 640, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("f5/d3", 642, 4'b0111, 7'b0000000, 1'b1);
      expect_pins("f5/d2", 674, 4'b1011, 7'b0000100, 1'b1);
      expect_pins("f5/d1", 706, 4'b1101, 7'b0011001, 1'b1);
      expect_pins("f5/d0", 738, 4'b1110, 7'b0110000, 1'b1);

      // Load on the wrap cycle itself goes straight to the display
      run_to(767);
      check_eq("ldw/fd", 32'(frame_done), 32'h1);
      do_load(767, {5'd12, 5'd13, 5'd14, 5'd15}, 4'b0000, 4'b0000);
      check_eq("ldw/lp", 32'(load_bus.load_pending), 32'h0);
      expect_pins("f6/d3", 770, 4'b0111, 7'b0001000, 1'b1);
      expect_pins("f6/d2", 802, 4'b1011, 7'b1000010, 1'b1);

      // Brightness 0: never past the guard while the nibble is 0
      run_to(896);
      brightness = 4'd0;
      expect_pins("b0/a", 898, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("b0/b", 910, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("b0/c", 930, 4'b1111, 7'b1111111, 1'b1);

      // Brightness 7: lit for dwell 2..15
      run_to(1024);
      brightness = 4'd7;
      expect_pins("b7/first", 1026, 4'b0111, 7'b0001000, 1'b1);
      expect_pins("b7/last", 1039, 4'b0111, 7'b0001000, 1'b1);
      expect_pins("b7/off", 1040, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("b7/d2last", 1071, 4'b1011, 7'b1000010, 1'b1);
      expect_pins("b7/d2off", 1072, 4'b1111, 7'b1111111, 1'b1);

      // Blink on digit 0, decimal point on digit 1
      do_load(1100, {5'd12, 5'd13, 5'd14, 5'd15}, 4'b0010, 4'b0001);
      run_to(1152);
      brightness = 4'd15;
      expect_pins("bl/d2", 1190, 4'b1011, 7'b1000010, 1'b1);
      expect_pins("bl/d1dp", 1220, 4'b1101, 7'b1000100, 1'b0);
      expect_pins("bl/d0on", 1250, 4'b1110, 7'b1000001, 1'b1);
      expect_pins("bl/d1dp2", 1350, 4'b1101, 7'b1000100, 1'b0);
      expect_pins("bl/d0off", 1380, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("bl/d0off2", 1399, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("bl/d0back", 1400, 4'b1110, 7'b1000001, 1'b1);

      // Undefined glyph code decodes to blank
      do_load(1410, {5'd31, 5'd13, 5'd14, 5'd15}, 4'b0000, 4'b0000);
      expect_pins("g31", 1540, 4'b0111, 7'b1111111, 1'b1);

      // enable is live
      run_to(1570);
      enable = 1'b0;
      expect_pins("en/off", 1570, 4'b1111, 7'b1111111, 1'b1);
      enable = 1'b1;
      expect_pins("en/on", 1571, 4'b1011, 7'b1000010, 1'b1);

      // Asynchronous reset mid-dwell with a load pending
      do_load(1600, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 4'b0000);
      check_eq("ar/lp_pre", 32'(load_bus.load_pending), 32'h1);
      expect_pins("ar/pre", 1610, 4'b1101, 7'b1000100, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar/an", 32'(anode), 32'hF);
      check_eq("ar/seg", 32'(led), 32'h7F);
      check_eq("ar/dp", 32'(dp), 32'h1);
      check_eq("ar/lp", 32'(load_bus.load_pending), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      s_now = 0;
      expect_pins("ar/guard", 1, 4'b1111, 7'b1111111, 1'b1);
      expect_pins("ar/d3", 2, 4'b0111, 7'b1111111, 1'b1);
      run_to(127);
      check_eq("ar/fd", 32'(frame_done), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
